// File: rtl/movement_pkg.sv
// Shared constants for the motion integrator: FSM state codes, velocity sign
// encoding and default playfield limits.
package movement_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STEP_X = 2'd1;
  localparam logic [1:0] STEP_Y = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic SIGN_POS = 1'b0;
  localparam logic SIGN_NEG = 1'b1;

  localparam int DEF_X_MAX = 319;
  localparam int DEF_Y_MAX = 239;

endpackage

// File: rtl/axis_stepper.sv
// One axis of the motion integrator: position register, remaining-step counter
// and edge handling (wrap by default, clamp when EDGE_CLAMP_EN is defined).
module axis_stepper
  import movement_pkg::*;
#(
  parameter int POS_W = 9,
  parameter int MAG_W = 3,
  parameter int MAX   = 319,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             step_en,
  input  logic             load,
  input  logic             sign_in,
  input  logic [MAG_W-1:0] mag,
  input  logic [POS_W-1:0] load_val,
  output logic [POS_W-1:0] pos,
  output logic             last,
  output logic             pending,
  output logic             hit
);

  localparam logic [POS_W-1:0] MAX_V  = POS_W'(MAX);
  localparam logic [POS_W-1:0] INIT_V = POS_W'(INIT);
  localparam logic [POS_W-1:0] ONE_P  = POS_W'(1);
  localparam logic [MAG_W-1:0] ONE_C  = MAG_W'(1);

  logic [MAG_W-1:0] cnt;
  logic             sign;
  logic [POS_W-1:0] pos_nx;
  logic             blocked;

  assign last    = (cnt == ONE_C);
  assign pending = (cnt != '0);

  // Position after one step in the latched direction.
  always_comb begin
    pos_nx  = pos;
    blocked = 1'b0;
`ifdef EDGE_CLAMP_EN
    if (sign == SIGN_NEG) begin
      if (pos == '0) blocked = 1'b1;
      else           pos_nx  = pos - ONE_P;
    end else begin
      if (pos >= MAX_V) blocked = 1'b1;
      else              pos_nx  = pos + ONE_P;
    end
`else
    if (sign == SIGN_NEG) pos_nx = (pos == '0) ? MAX_V : pos - ONE_P;
    else                  pos_nx = (pos >= MAX_V) ? '0 : pos + ONE_P;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos  <= INIT_V;
      cnt  <= '0;
      sign <= SIGN_POS;
    end else if (load) begin
      pos <= (load_val > MAX_V) ? MAX_V : load_val;
      cnt <= '0;
    end else if (start) begin
      cnt  <= mag;
      sign <= sign_in;
    end else if (step_en) begin
      cnt <= cnt - ONE_C;
      pos <= pos_nx;
    end
  end

`ifdef EDGE_CLAMP_EN
  // Registered so the pulse lines up with the cycle the position would have moved.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     hit <= 1'b0;
    else if (load)    hit <= 1'b0;
    else              hit <= step_en & blocked;
  end
`else
  assign hit = 1'b0;
`endif

endmodule

// File: rtl/motion_integrator.sv
// Integrates a sign+magnitude velocity into an (x,y) screen position, one unit
// step per clock after each move_tick. Optional macro: EDGE_CLAMP_EN.
module motion_integrator
  import movement_pkg::*;
#(
  parameter int POS_W  = 9,
  parameter int MAG_W  = 3,
  parameter int X_MAX  = DEF_X_MAX,
  parameter int Y_MAX  = DEF_Y_MAX,
  parameter int X_INIT = 0,
  parameter int Y_INIT = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             move_tick,
  input  logic             vel_x_sign,
  input  logic [MAG_W-1:0] vel_x_mag,
  input  logic             vel_y_sign,
  input  logic [MAG_W-1:0] vel_y_mag,
  input  logic             load_pos,
  input  logic [POS_W-1:0] load_x,
  input  logic [POS_W-1:0] load_y,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             busy,
  output logic             step_done,
  output logic             missed_tick,
  output logic             edge_hit,
  output logic [1:0]       fsm_state
);

  logic [1:0] state, state_nx;
  logic       start;
  logic       x_last, x_pending, x_hit;
  logic       y_last, y_pending, y_hit;

  // Velocity is captured only on an accepted tick; load_pos wins over a same-cycle tick.
  assign start     = (state == IDLE) && move_tick && !load_pos;
  assign fsm_state = state;
  assign edge_hit  = x_hit | y_hit;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (move_tick) begin
          if (vel_x_mag != '0)      state_nx = STEP_X;
          else if (vel_y_mag != '0) state_nx = STEP_Y;
          else                      state_nx = DONE;
        end
      end
      STEP_X: begin
        if (x_last || !x_pending) state_nx = y_pending ? STEP_Y : DONE;
      end
      STEP_Y: begin
        if (y_last || !y_pending) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      step_done   <= 1'b0;
      missed_tick <= 1'b0;
    end else if (load_pos) begin
      state       <= IDLE;
      busy        <= 1'b0;
      step_done   <= 1'b0;
      missed_tick <= 1'b0;
    end else begin
      state       <= state_nx;
      busy        <= (state_nx != IDLE);
      step_done   <= (state_nx == DONE);
      missed_tick <= move_tick && (state != IDLE);
    end
  end

  axis_stepper #(
    .POS_W(POS_W), .MAG_W(MAG_W), .MAX(X_MAX), .INIT(X_INIT)
  ) u_axis_x (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .step_en  (state == STEP_X),
    .load     (load_pos),
    .sign_in  (vel_x_sign),
    .mag      (vel_x_mag),
    .load_val (load_x),
    .pos      (pos_x),
    .last     (x_last),
    .pending  (x_pending),
    .hit      (x_hit)
  );

  axis_stepper #(
    .POS_W(POS_W), .MAG_W(MAG_W), .MAX(Y_MAX), .INIT(Y_INIT)
  ) u_axis_y (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .step_en  (state == STEP_Y),
    .load     (load_pos),
    .sign_in  (vel_y_sign),
    .mag      (vel_y_mag),
    .load_val (load_y),
    .pos      (pos_y),
    .last     (y_last),
    .pending  (y_pending),
    .hit      (y_hit)
  );

endmodule

// File: tb/tb_motion_integrator.sv
// Directed plus randomized bench for motion_integrator; expected cycle-by-cycle
// outputs come from a plain-arithmetic model of the movement rules.
module tb_motion_integrator;

  localparam int POS_W  = 9;
  localparam int MAG_W  = 3;
  localparam int X_MAX  = 319;
  localparam int Y_MAX  = 239;
  localparam int X_INIT = 10;
  localparam int Y_INIT = 20;
  localparam int W      = 4 + 2 * POS_W;

  logic             clk;
  logic             reset_n;
  logic             move_tick;
  logic             vel_x_sign, vel_y_sign;
  logic [MAG_W-1:0] vel_x_mag, vel_y_mag;
  logic             load_pos;
  logic [POS_W-1:0] load_x, load_y;
  logic [POS_W-1:0] pos_x, pos_y;
  logic             busy, step_done, missed_tick, edge_hit;
  logic [1:0]       fsm_state;

  motion_integrator #(
    .POS_W(POS_W), .MAG_W(MAG_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .X_INIT(X_INIT), .Y_INIT(Y_INIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .move_tick(move_tick),
    .vel_x_sign(vel_x_sign), .vel_x_mag(vel_x_mag),
    .vel_y_sign(vel_y_sign), .vel_y_mag(vel_y_mag),
    .load_pos(load_pos), .load_x(load_x), .load_y(load_y),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .step_done(step_done),
    .missed_tick(missed_tick), .edge_hit(edge_hit), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [W-1:0] exp_q[$];
  int mx, my;

  function automatic int model_step(input int p, input logic neg, input int maxv,
                                    output bit hit);
    hit = 1'b0;
`ifdef EDGE_CLAMP_EN
    if (neg) begin
      if (p == 0) hit = 1'b1; else p = p - 1;
    end else begin
      if (p == maxv) hit = 1'b1; else p = p + 1;
    end
    return p;
`else
    return neg ? (p + maxv) % (maxv + 1) : (p + 1) % (maxv + 1);
`endif
  endfunction

  function automatic logic [W-1:0] pack(input bit missed, input bit hit,
                                        input bit done, input bit bsy);
    return {missed, hit, done, bsy, POS_W'(mx), POS_W'(my)};
  endfunction

  function automatic logic [W-1:0] observed();
    return {missed_tick, edge_hit, step_done, busy, pos_x, pos_y};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int x, input int y);
    load_pos = 1'b1;
    load_x   = POS_W'(x);
    load_y   = POS_W'(y);
    next_cycle();
    load_pos = 1'b0;
    mx = (x > X_MAX) ? X_MAX : x;
    my = (y > Y_MAX) ? Y_MAX : y;
    check("load", observed(), pack(0, 0, 0, 0));
  endtask

  // One tick; extra_at >= 0 drives a second tick after that many observed cycles.
  task automatic run_move(input string tag, input logic sx, input int xm,
                          input logic sy, input int ym, input int extra_at);
    int  total;
    bit  hit;
    total = xm + ym;
    exp_q.delete();
    exp_q.push_back(pack(0, 0, total == 0, 1));
    for (int s = 1; s <= total; s++) begin
      if (s <= xm) mx = model_step(mx, sx, X_MAX, hit);
      else         my = model_step(my, sy, Y_MAX, hit);
      exp_q.push_back(pack(extra_at >= 0 && s == extra_at + 1, hit, s == total, 1));
    end
    exp_q.push_back(pack(extra_at >= 0 && total + 1 == extra_at + 1, 0, 0, 0));
    vel_x_sign = sx;
    vel_x_mag  = MAG_W'(xm);
    vel_y_sign = sy;
    vel_y_mag  = MAG_W'(ym);
    move_tick  = 1'b1;
    for (int idx = 0; exp_q.size() > 0; idx++) begin
      next_cycle();
      move_tick = (idx == extra_at);
      vel_x_mag = MAG_W'($urandom_range(0, 7));
      vel_y_mag = MAG_W'($urandom_range(0, 7));
      check(tag, observed(), exp_q.pop_front());
    end
  endtask

  initial begin
    reset_n = 1'b0; move_tick = 1'b0; load_pos = 1'b0;
    load_x = '0; load_y = '0;
    vel_x_sign = 1'b0; vel_y_sign = 1'b0; vel_x_mag = '0; vel_y_mag = '0;
    mx = X_INIT; my = Y_INIT;
    #12;
    check("reset_out", observed(), pack(0, 0, 0, 0));
    check("reset_state", {{(W-2){1'b0}}, fsm_state}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    check("post_reset", observed(), pack(0, 0, 0, 0));

    // Basic move, wrap corner, zero velocity
    do_load(100, 50);
    run_move("move_p3_m2", 1'b0, 3, 1'b1, 2, -1);
    do_load(319, 0);
    run_move("wrap_corner", 1'b0, 1, 1'b1, 1, -1);
    do_load(7, 7);
    run_move("zero_vel", 1'b0, 0, 1'b0, 0, -1);

    // Overrun: second tick three cycles after the first
    do_load(300, 100);
    run_move("overrun", 1'b0, 7, 1'b0, 0, 2);

    // Load with a same-cycle tick while stepping y
    do_load(100, 50);
    vel_x_sign = 1'b0; vel_x_mag = 3'd1; vel_y_sign = 1'b0; vel_y_mag = 3'd3;
    move_tick = 1'b1;
    next_cycle();
    move_tick = 1'b0;
    next_cycle();
    mx = 101;
    check("abort_x_step", observed(), pack(0, 0, 0, 1));
    next_cycle();
    my = 51;
    check("abort_y_step", observed(), pack(0, 0, 0, 1));
    load_pos = 1'b1; load_x = 9'd400; load_y = 9'd5; move_tick = 1'b1;
    next_cycle();
    load_pos = 1'b0; move_tick = 1'b0;
    mx = X_MAX; my = 5;
    check("abort_load", observed(), pack(0, 0, 0, 0));
    check("abort_state", {{(W-2){1'b0}}, fsm_state}, '0);
    next_cycle();
    check("abort_quiet", observed(), pack(0, 0, 0, 0));

    // Asynchronous reset in the middle of x stepping
    do_load(200, 100);
    vel_x_sign = 1'b0; vel_x_mag = 3'd5; vel_y_mag = 3'd0;
    move_tick = 1'b1;
    next_cycle();
    move_tick = 1'b0;
    next_cycle();
    mx = 201;
    check("pre_reset_step", observed(), pack(0, 0, 0, 1));
    #2 reset_n = 1'b0;
    #1;
    mx = X_INIT; my = Y_INIT;
    check("async_reset", observed(), pack(0, 0, 0, 0));
    check("async_reset_state", {{(W-2){1'b0}}, fsm_state}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    check("after_async_reset", observed(), pack(0, 0, 0, 0));

    // Randomized moves, often starting near the playfield edges
    for (int n = 0; n < 24; n++) begin
      int xm, ym, ex;
      case ($urandom_range(0, 3))
        0: do_load($urandom_range(0, 511), $urandom_range(0, 511));
        1: do_load($urandom_range(0, 2), $urandom_range(Y_MAX - 2, Y_MAX));
        2: do_load($urandom_range(X_MAX - 2, X_MAX), $urandom_range(0, 2));
        default: ;
      endcase
      xm = $urandom_range(0, 7);
      ym = $urandom_range(0, 7);
      ex = ($urandom_range(0, 2) == 0) ? $urandom_range(0, xm + ym) : -1;
      run_move("random_move", 1'($urandom_range(0, 1)), xm, 1'($urandom_range(0, 1)), ym, ex);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
